// File: rtl/fa_pipe.sv
// fa_pipe: carry-chained pipelined adder/subtractor, one CHUNK-bit slice per stage.
// Optional signed-overflow output enabled by defining FA_PIPE_OVF_EN.
module fa_pipe #(
    parameter int W     = 24,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s,
`ifdef FA_PIPE_OVF_EN
    output logic         ovf,
`endif
    output logic         cout
);

    localparam int STAGES = W / CHUNK;

    logic         w_adv;
    logic [W-1:0] w_b_eff;
    logic         w_cin_eff;

    assign w_adv     = !out_valid || out_ready;
    assign in_ready  = w_adv;
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = cin ^ sub;

`ifdef FA_PIPE_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
`endif

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_st
            localparam int RIN = W - k * CHUNK;

            logic [RIN-1:0]         w_a;
            logic [RIN-1:0]         w_b;
            logic                   w_c;
            logic                   w_v;
            logic [CHUNK:0]         w_sum;
            logic [(k+1)*CHUNK-1:0] w_pn;

            logic                   r_v;
            logic                   r_c;
            logic [(k+1)*CHUNK-1:0] r_p;

            assign w_sum = {1'b0, w_a[CHUNK-1:0]}
                         + {1'b0, w_b[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, w_c};

            if (k == 0) begin : g_in
                assign w_a  = a;
                assign w_b  = w_b_eff;
                assign w_c  = w_cin_eff;
                assign w_v  = in_valid;
                assign w_pn = w_sum[CHUNK-1:0];
            end else begin : g_in
                assign w_a  = g_st[k-1].g_op.r_a;
                assign w_b  = g_st[k-1].g_op.r_b;
                assign w_c  = g_st[k-1].r_c;
                assign w_v  = g_st[k-1].r_v;
                assign w_pn = {w_sum[CHUNK-1:0], g_st[k-1].r_p};
            end

            // Data only moves with a real beat, so outputs hold across bubbles.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_p <= '0;
                end else if (w_adv) begin
                    r_v <= w_v;
                    if (w_v) begin
                        r_c <= w_sum[CHUNK];
                        r_p <= w_pn;
                    end
                end
            end

            if (k < STAGES - 1) begin : g_op
                logic [RIN-CHUNK-1:0] r_a;
                logic [RIN-CHUNK-1:0] r_b;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_adv && w_v) begin
                        r_a <= w_a[RIN-1:CHUNK];
                        r_b <= w_b[RIN-1:CHUNK];
                    end
                end
            end

`ifdef FA_PIPE_OVF_EN
            if (k == STAGES - 1) begin : g_ov
                // Top operand slice still carries the sign bits of a and b_eff.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_ovf <= 1'b0;
                    end else if (w_adv && w_v) begin
                        r_ovf <= (w_a[CHUNK-1] == w_b[CHUNK-1]) &&
                                 (w_sum[CHUNK-1] != w_a[CHUNK-1]);
                    end
                end
            end
`endif
        end
    endgenerate

    assign out_valid = g_st[STAGES-1].r_v;
    assign cout      = g_st[STAGES-1].r_c;
    assign s         = g_st[STAGES-1].r_p;

endmodule
